// File: rtl/prbs_burst_ctrl_pkg.sv
// Shared encodings and constants for the PRBS31 burst sequencer.
package prbs_burst_ctrl_pkg;

  localparam int unsigned SEED_W = 31;
  localparam int unsigned PRBS_TAP_A = 31;
  localparam int unsigned PRBS_TAP_B = 28;
  localparam logic [SEED_W-1:0] PRBS_SEED_DEFAULT = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_START = 2'd1,
    OP_PAUSE = 2'd2,
    OP_ABORT = 2'd3
  } cmd_op_e;

endpackage

// File: rtl/prbs_burst_ctrl_rate_div.sv
// Step pacer: counts up to the divider value and ticks on terminal count.
module prbs_burst_ctrl_rate_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_c_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_c_o = en_i && run_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i)         cnt_d = '0;
      else if (tick_c_o) cnt_d = '0;
      else if (run_i)    cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prbs_burst_ctrl.sv
// PRBS31 burst sequencer: command handshake, seed load, paced LFSR stepping
// and burst-length accounting.
module prbs_burst_ctrl
  import prbs_burst_ctrl_pkg::*;
#(
  parameter int unsigned        LEN_W        = 16,
  parameter int unsigned        DIV_W        = 8,
  parameter logic [SEED_W-1:0]  SEED_DEFAULT = PRBS_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [SEED_W-1:0] seed_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [DIV_W-1:0]  rate_div_i,
  output logic              lfsr_load_o,
  output logic [SEED_W-1:0] lfsr_seed_o,
  output logic              lfsr_step_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  bit_count_o,
  output logic [2:0]        state_o
);

  state_e            state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  bit_count_q, bit_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic    step_c;
  logic    fire_c;
  logic    last_step_c;
  cmd_op_e op_c;

  assign cmd_ready_o = ena_i && (state_q != ST_LOAD);
  assign fire_c      = cmd_valid_i && cmd_ready_o;
  assign op_c        = cmd_op_e'(cmd_op_i);
  assign last_step_c = step_c && (len_q != '0) && ((bit_count_q + LEN_W'(1)) == len_q);

  prbs_burst_ctrl_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ena_i),
    .clr_i    (state_q == ST_LOAD),
    .run_i    (state_q == ST_RUN),
    .div_i    (div_q),
    .tick_c_o (step_c)
  );

  // Next-state, capture and counter logic; everything holds while ena is low.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    len_d       = len_q;
    div_d       = div_q;
    bit_count_d = bit_count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    if (ena_i) begin
      done_d = 1'b0;
      if (state_q == ST_LOAD) bit_count_d = '0;
      else if (step_c)        bit_count_d = bit_count_q + LEN_W'(1);

      unique case (state_q)
        ST_IDLE: if (fire_c && op_c == OP_START) state_d = ST_LOAD;
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          // Abort and restart override completion; completion overrides pause.
          if (fire_c && op_c == OP_ABORT)      state_d = ST_IDLE;
          else if (fire_c && op_c == OP_START) state_d = ST_LOAD;
          else if (last_step_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
          else if (fire_c && op_c == OP_PAUSE) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (fire_c && op_c == OP_ABORT)      state_d = ST_IDLE;
          else if (fire_c && op_c == OP_START) state_d = ST_LOAD;
          else if (fire_c && op_c == OP_PAUSE) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (fire_c && op_c == OP_ABORT)      state_d = ST_IDLE;
          else if (fire_c && op_c == OP_START) state_d = ST_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase

      if (fire_c && op_c == OP_START) begin
        seed_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
        len_d  = burst_len_i;
        div_d  = rate_div_i;
      end
      busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seed_q      <= SEED_DEFAULT;
      len_q       <= '0;
      div_q       <= '0;
      bit_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      div_q       <= div_d;
      bit_count_q <= bit_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lfsr_load_o = ena_i && (state_q == ST_LOAD);
  assign lfsr_step_o = step_c;
  assign lfsr_seed_o = seed_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bit_count_o = bit_count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed bench for the PRBS31 burst sequencer: vector table plus
// hand-written multi-cycle sequences.
module tb_prbs_burst_ctrl;

  localparam logic [30:0] DEF = 31'h7FFF_FFFF;

  logic        clk, rst_n, ena;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [30:0] seed;
  logic [15:0] burst_len;
  logic [7:0]  rate_div;
  logic        lfsr_load, lfsr_step, busy, done;
  logic [30:0] lfsr_seed;
  logic [15:0] bit_count;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  prbs_burst_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena_i       (ena),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .seed_i      (seed),
    .burst_len_i (burst_len),
    .rate_div_i  (rate_div),
    .lfsr_load_o (lfsr_load),
    .lfsr_seed_o (lfsr_seed),
    .lfsr_step_o (lfsr_step),
    .busy_o      (busy),
    .done_o      (done),
    .bit_count_o (bit_count),
    .state_o     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [30:0] sd;
    logic [15:0] len;
    logic [7:0]  div;
    logic [2:0]  e_st;
    logic        e_rdy, e_ld, e_stp, e_bsy, e_dn;
    logic [15:0] e_cnt;
    logic [30:0] e_seed;
  } vec_t;

  localparam int NV = 42;
  vec_t vt [NV];

  function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [30:0] sd,
                              input logic [15:0] len, input logic [7:0] div,
                              input logic [2:0] st, input logic rdy, input logic ld,
                              input logic stp, input logic bsy, input logic dn,
                              input logic [15:0] cnt, input logic [30:0] es);
    vec_t r;
    r.v = v; r.op = op; r.sd = sd; r.len = len; r.div = div;
    r.e_st = st; r.e_rdy = rdy; r.e_ld = ld; r.e_stp = stp; r.e_bsy = bsy;
    r.e_dn = dn; r.e_cnt = cnt; r.e_seed = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [30:0] sd,
                       input logic [15:0] len, input logic [7:0] div);
    cmd_valid = v; cmd_op = op; seed = sd; burst_len = len; rate_div = div;
  endtask

  task automatic nop();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  // Runs until done pulses or the budget expires; index 0 is the current cycle.
  task automatic run_to_done(input int budget, output int nsteps, output int first_idx,
                             output int done_idx);
    nsteps = 0; first_idx = -1; done_idx = -1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (lfsr_step) begin
        if (nsteps == 0) first_idx = k;
        nsteps++;
      end
      if (done) begin
        done_idx = k;
        break;
      end
      next_cyc();
    end
  endtask

  initial begin
    int ns, fi, di, bad, k;

    // Burst len4/div0, then seed-0 len3/div2, abort on final step,
    // pause on final step, restart on final step.
    vt[0]  = mk(1, 1, 31'd1, 16'd4, 8'd0, 0, 1, 0, 0, 0, 0, 16'd0, DEF);
    vt[1]  = mk(0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0, 16'd0, 31'd1);
    vt[2]  = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd0, 31'd1);
    vt[3]  = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd1, 31'd1);
    vt[4]  = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd2, 31'd1);
    vt[5]  = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd3, 31'd1);
    vt[6]  = mk(0, 0, 0, 0, 0,            4, 1, 0, 0, 0, 1, 16'd4, 31'd1);
    vt[7]  = mk(0, 0, 0, 0, 0,            4, 1, 0, 0, 0, 0, 16'd4, 31'd1);
    vt[8]  = mk(1, 1, 31'd0, 16'd3, 8'd2, 4, 1, 0, 0, 0, 0, 16'd4, 31'd1);
    vt[9]  = mk(0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0, 16'd4, DEF);
    vt[10] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd0, DEF);
    vt[11] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd0, DEF);
    vt[12] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd0, DEF);
    vt[13] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd1, DEF);
    vt[14] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd1, DEF);
    vt[15] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd1, DEF);
    vt[16] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd2, DEF);
    vt[17] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd2, DEF);
    vt[18] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd2, DEF);
    vt[19] = mk(0, 0, 0, 0, 0,            4, 1, 0, 0, 0, 1, 16'd3, DEF);
    vt[20] = mk(0, 0, 0, 0, 0,            4, 1, 0, 0, 0, 0, 16'd3, DEF);
    vt[21] = mk(1, 1, 31'd5, 16'd2, 8'd0, 4, 1, 0, 0, 0, 0, 16'd3, DEF);
    vt[22] = mk(0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0, 16'd3, 31'd5);
    vt[23] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd0, 31'd5);
    vt[24] = mk(1, 3, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd1, 31'd5);
    vt[25] = mk(1, 2, 0, 0, 0,            0, 1, 0, 0, 0, 0, 16'd2, 31'd5);
    vt[26] = mk(1, 3, 0, 0, 0,            0, 1, 0, 0, 0, 0, 16'd2, 31'd5);
    vt[27] = mk(1, 1, 31'd9, 16'd2, 8'd0, 0, 1, 0, 0, 0, 0, 16'd2, 31'd5);
    vt[28] = mk(0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0, 16'd2, 31'd9);
    vt[29] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd0, 31'd9);
    vt[30] = mk(1, 2, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd1, 31'd9);
    vt[31] = mk(0, 0, 0, 0, 0,            4, 1, 0, 0, 0, 1, 16'd2, 31'd9);
    vt[32] = mk(1, 2, 0, 0, 0,            4, 1, 0, 0, 0, 0, 16'd2, 31'd9);
    vt[33] = mk(1, 1, 31'd3, 16'd1, 8'd0, 4, 1, 0, 0, 0, 0, 16'd2, 31'd9);
    vt[34] = mk(0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0, 16'd2, 31'd3);
    vt[35] = mk(1, 1, 31'd4, 16'd2, 8'd1, 2, 1, 0, 1, 1, 0, 16'd0, 31'd3);
    vt[36] = mk(0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0, 16'd1, 31'd4);
    vt[37] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd0, 31'd4);
    vt[38] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd0, 31'd4);
    vt[39] = mk(0, 0, 0, 0, 0,            2, 1, 0, 0, 1, 0, 16'd1, 31'd4);
    vt[40] = mk(0, 0, 0, 0, 0,            2, 1, 0, 1, 1, 0, 16'd1, 31'd4);
    vt[41] = mk(0, 0, 0, 0, 0,            4, 1, 0, 0, 0, 1, 16'd2, 31'd4);

    rst_n = 1'b0; ena = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cyc();
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.count", 32'(bit_count), 32'd0);
    chk("rst.seed", 32'(lfsr_seed), 32'(DEF));
    chk("rst.ready", 32'(cmd_ready), 32'd1);
    chk("rst.busy_done", 32'({busy, done, lfsr_load, lfsr_step}), 32'd0);
    next_cyc();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].op, vt[i].sd, vt[i].len, vt[i].div);
      #1;
      chk($sformatf("v%0d.state", i), 32'(state), 32'(vt[i].e_st));
      chk($sformatf("v%0d.ready", i), 32'(cmd_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d.load", i), 32'(lfsr_load), 32'(vt[i].e_ld));
      chk($sformatf("v%0d.step", i), 32'(lfsr_step), 32'(vt[i].e_stp));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].e_bsy));
      chk($sformatf("v%0d.done", i), 32'(done), 32'(vt[i].e_dn));
      chk($sformatf("v%0d.count", i), 32'(bit_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d.seed", i), 32'(lfsr_seed), 32'(vt[i].e_seed));
      next_cyc();
    end
    nop();

    // Free-run: 65536 steps wrap the counter back to 0 without completing.
    drive(1, 1, 31'h55, 16'd0, 8'd0);
    next_cyc();
    nop();
    next_cyc();
    bad = 0;
    for (k = 0; k < 65536; k++) begin
      if (!busy || done || !lfsr_step) bad++;
      if (k == 65535) chk("free.count_max", 32'(bit_count), 32'hFFFF);
      next_cyc();
    end
    chk("free.bad_cycles", 32'(bad), 32'd0);
    chk("free.count_wrap", 32'(bit_count), 32'd0);
    chk("free.state", 32'(state), 32'd2);
    drive(1, 3, 0, 0, 0);
    next_cyc();
    nop();
    #1;
    chk("free.abort_state", 32'(state), 32'd0);
    chk("free.abort_count", 32'(bit_count), 32'd1);
    next_cyc();

    // Pause after three steps, hold for 20 cycles, resume in the same phase.
    drive(1, 1, 31'h1234, 16'd10, 8'd1);
    next_cyc();
    nop();
    next_cyc();
    for (k = 2; k < 8; k++) begin
      #1;
      chk($sformatf("pause.pre_step%0d", k), 32'(lfsr_step), 32'(k % 2 == 1));
      next_cyc();
    end
    drive(1, 2, 0, 0, 0);
    #1;
    chk("pause.count_at_pause", 32'(bit_count), 32'd3);
    next_cyc();
    nop();
    bad = 0;
    for (k = 0; k < 20; k++) begin
      #1;
      if (lfsr_step || state != 3'd3 || bit_count != 16'd3) bad++;
      next_cyc();
    end
    chk("pause.frozen", 32'(bad), 32'd0);
    drive(1, 2, 0, 0, 0);
    next_cyc();
    nop();
    run_to_done(40, ns, fi, di);
    chk("pause.resume_first", 32'(fi), 32'd0);
    chk("pause.resume_steps", 32'(ns), 32'd7);
    chk("pause.done_idx", 32'(di), 32'd13);
    chk("pause.total", 32'(bit_count), 32'd10);
    next_cyc();

    // Asynchronous reset in the middle of a burst.
    drive(1, 1, 31'h77, 16'd10, 8'd0);
    next_cyc();
    nop();
    repeat (3) next_cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.state", 32'(state), 32'd0);
    chk("mrst.count", 32'(bit_count), 32'd0);
    chk("mrst.seed", 32'(lfsr_seed), 32'(DEF));
    chk("mrst.outs", 32'({busy, done, lfsr_load, lfsr_step}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    next_cyc();

    // ena low mid-RUN: full freeze, commands ignored, exact resume.
    drive(1, 1, 31'd5, 16'd4, 8'd2);
    next_cyc();
    nop();
    repeat (3) next_cyc();
    ena = 1'b0;
    drive(1, 1, 31'd6, 16'd9, 8'd0);
    bad = 0;
    for (k = 0; k < 5; k++) begin
      #1;
      if (lfsr_step || lfsr_load || cmd_ready || state != 3'd2 || bit_count != 16'd0) bad++;
      next_cyc();
    end
    chk("ena.frozen", 32'(bad), 32'd0);
    nop();
    ena = 1'b1;
    run_to_done(40, ns, fi, di);
    chk("ena.resume_first", 32'(fi), 32'd0);
    chk("ena.steps", 32'(ns), 32'd4);
    chk("ena.done_idx", 32'(di), 32'd10);
    chk("ena.count", 32'(bit_count), 32'd4);
    chk("ena.seed", 32'(lfsr_seed), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
